// File: rtl/filter2d_pkg.sv
// Shared state encoding, default frame geometry and counter width for the filter frame sequencer.
package filter2d_pkg;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int NTAP_DEF  = 9;
  localparam int CNT_W     = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/filter2d_coef_bank.sv
// Host-writable coefficient shadow bank: writes land only while idle and in range, others pulse err.
module filter2d_coef_bank
  import filter2d_pkg::*;
#(
  parameter int NTAP = NTAP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic       we,
  input  logic [3:0] idx,
  input  logic [7:0] data,
  output logic       err,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data
);
  logic [7:0] bank [NTAP];
  logic       idx_ok;
  logic       accept;

  assign idx_ok = {1'b0, idx} < 5'(NTAP);
  assign accept = we && idx_ok && idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) bank[i] <= '0;
      err <= 1'b0;
    end else begin
      err <= we && !accept;
      for (int i = 0; i < NTAP; i++) begin
        if (accept && idx == 4'(i)) bank[i] <= data;
      end
    end
  end

  // Out-of-range read indices return zero rather than aliasing a real tap.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (rd_idx == 4'(i)) rd_data = bank[i];
    end
  end
endmodule

// File: rtl/filter2d_seq.sv
// Frame sequencer: loads NTAP coefficients into the filter, streams one paced frame of pixels,
// then waits for the filter to return every output before flagging completion.
module filter2d_seq
  import filter2d_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int NTAP  = NTAP_DEF,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_idx,
  input  logic [7:0]       cfg_data,
  output logic             cfg_err,
  input  logic             go,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             src_req,
  input  logic             src_valid,
  input  logic [7:0]       src_data,
  output logic             f_h_write,
  output logic [3:0]       f_h_idx,
  output logic [7:0]       f_h_data,
  output logic             f_i_strb,
  output logic [7:0]       f_i_data,
  input  logic             f_o_strb,
  output logic [CNT_W-1:0] out_cnt
);
  localparam logic [CNT_W-1:0] TOT    = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] TOT_M1 = CNT_W'(IMG_W * IMG_H - 1);
  localparam int               GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           state, state_nx;
  logic [3:0]       tap;
  logic [CNT_W-1:0] in_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       coef;
  logic             xfer;
  logic             start;
  logic             counting;
  logic             pass;

  filter2d_coef_bank #(.NTAP(NTAP)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .idle    (state == S_IDLE),
    .we      (cfg_we),
    .idx     (cfg_idx),
    .data    (cfg_data),
    .err     (cfg_err),
    .rd_idx  (tap),
    .rd_data (coef)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    f_h_write = 1'b0;
    src_req   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_nx = S_LOAD;
      end
      S_LOAD: begin
        f_h_write = 1'b1;
        if (tap == 4'(NTAP - 1)) state_nx = S_STREAM;
      end
      S_STREAM: begin
        src_req = (in_cnt < TOT) && (gap_cnt == '0);
        if (src_req && src_valid && in_cnt == TOT_M1) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_cnt == TOT) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort wins over every transition, including completion out of DRAIN.
    if (abort && state != S_IDLE) state_nx = S_IDLE;
  end

  assign f_h_idx  = f_h_write ? tap  : '0;
  assign f_h_data = f_h_write ? coef : '0;

  assign start    = (state == S_IDLE) && go;
  assign xfer     = src_req && src_valid;
  assign pass     = xfer && !abort;
  assign counting = (state == S_STREAM) || (state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap      <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      gap_cnt  <= '0;
      f_i_strb <= 1'b0;
      f_i_data <= '0;
    end else begin
      f_i_strb <= pass;
      f_i_data <= pass ? src_data : '0;
      if (start) begin
        tap     <= '0;
        in_cnt  <= '0;
        out_cnt <= '0;
        gap_cnt <= '0;
      end else begin
        if (state == S_LOAD) tap <= tap + 4'd1;
        // The gap counter reloads on each accepted pixel and gates src_req until it drains.
        if (xfer) begin
          in_cnt  <= in_cnt + CNT_W'(1);
          gap_cnt <= GW'(GAP);
        end else if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GW'(1);
        end
        if (counting && f_o_strb && out_cnt != TOT) out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_filter2d_seq.sv
// Runs a GAP=0 and a GAP=2 sequencer side by side on a 4x4 frame against a transaction-level model.
`timescale 1ns/1ps
module tb_filter2d_seq;
  localparam int W = 4, H = 4, NT = 9, TOT = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_idx = '0;
  logic [7:0] cfg_data = '0;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = '0;
  logic       extra_o = 1'b0;
  bit         rnd_valid = 1'b0;

  logic [1:0]       cfg_err, busy, done, src_req, h_write, i_strb, o_strb;
  logic [1:0][3:0]  h_idx;
  logic [1:0][7:0]  h_data, i_data;
  logic [1:0][16:0] out_cnt;
  logic [7:0]       bank_m [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int GP = 2 * g;
    logic [2:0] dly;
    int         mdl_in, mdl_out, since, tap_m;
    bit         pend;
    logic [7:0] pend_d;

    filter2d_seq #(.IMG_W(W), .IMG_H(H), .NTAP(NT), .GAP(GP)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
      .cfg_err(cfg_err[g]), .go(go), .abort(abort), .busy(busy[g]), .done(done[g]),
      .src_req(src_req[g]), .src_valid(src_valid), .src_data(src_data),
      .f_h_write(h_write[g]), .f_h_idx(h_idx[g]), .f_h_data(h_data[g]),
      .f_i_strb(i_strb[g]), .f_i_data(i_data[g]), .f_o_strb(o_strb[g]), .out_cnt(out_cnt[g])
    );

    // Filter stand-in: each input strobe comes back as an output strobe three cycles later.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) dly <= '0;
      else     dly <= {dly[1:0], i_strb[g]};
    end
    assign o_strb[g] = dly[2] | extra_o;

    initial forever begin
      @(negedge clk);
      if (rst) begin
        mdl_in = 0; mdl_out = 0; since = 100; tap_m = 0; pend = 0; pend_d = '0;
      end else begin
        chk($sformatf("g%0d f_i_strb", g), 32'(i_strb[g]), 32'(pend));
        if (pend) chk($sformatf("g%0d f_i_data", g), 32'(i_data[g]), 32'(pend_d));
        chk($sformatf("g%0d out_cnt", g), 32'(out_cnt[g]), mdl_out);
        if (src_req[g]) chk($sformatf("g%0d gap spacing", g), 32'(since > GP), 1);
        if (mdl_in >= TOT) chk($sformatf("g%0d src_req past TOT", g), 32'(src_req[g]), 0);
        if (h_write[g]) begin
          chk($sformatf("g%0d h_idx", g), 32'(h_idx[g]), tap_m);
          chk($sformatf("g%0d h_data", g), 32'(h_data[g]), 32'(bank_m[tap_m]));
          tap_m++;
        end
        if (busy[g] && !h_write[g] && !done[g] && o_strb[g] && mdl_out < TOT) mdl_out++;
        if (src_req[g] && src_valid) begin
          mdl_in++;
          since = 1;
        end else begin
          since++;
        end
        pend   = src_req[g] && src_valid && !abort;
        pend_d = src_data;
        if (go && !busy[g]) begin
          mdl_in = 0; mdl_out = 0; tap_m = 0; since = 100;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    src_data = 8'($urandom);
    if (rnd_valid) src_valid = 1'($urandom_range(0, 1));
    else           src_valid = 1'b1;
  end

  task automatic cfg_write(input int idx, input int dat, input bit acc);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_data = 8'(dat);
    tick();
    cfg_we = 1'b0;
    for (int g = 0; g < 2; g++)
      chk($sformatf("g%0d cfg_err idx%0d", g, idx), 32'(cfg_err[g]), 32'(!acc));
    if (acc) bank_m[idx] = 8'(dat);
  endtask

  task automatic chk_all_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s g%0d busy", nm, g), 32'(busy[g]), 0);
      chk($sformatf("%s g%0d done", nm, g), 32'(done[g]), 0);
      chk($sformatf("%s g%0d src_req", nm, g), 32'(src_req[g]), 0);
      chk($sformatf("%s g%0d h_write", nm, g), 32'(h_write[g]), 0);
      chk($sformatf("%s g%0d h_idx", nm, g), 32'(h_idx[g]), 0);
      chk($sformatf("%s g%0d h_data", nm, g), 32'(h_data[g]), 0);
      chk($sformatf("%s g%0d i_strb", nm, g), 32'(i_strb[g]), 0);
      chk($sformatf("%s g%0d out_cnt", nm, g), 32'(out_cnt[g]), 0);
      chk($sformatf("%s g%0d cfg_err", nm, g), 32'(cfg_err[g]), 0);
    end
  endtask

  task automatic run_frame(input string nm, input bit rv, input bit rej, input bit inj);
    int stb[2], first[2], last[2], dn[2], hw[2], hwf[2], hwl[2];
    int cyc;
    bit rej_pend, rej_done;
    rnd_valid = rv;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s g%0d busy after go", nm, g), 32'(busy[g]), 1);
      stb[g] = 0; first[g] = 0; last[g] = 0; dn[g] = 0; hw[g] = 0; hwf[g] = 0; hwl[g] = 0;
    end
    cyc = 0; rej_pend = 0; rej_done = 0;
    while (busy != 2'b00 && cyc < 600) begin
      cfg_we = 1'b0;
      if (rej_pend) begin
        for (int g = 0; g < 2; g++)
          chk($sformatf("%s g%0d cfg_err busy write", nm, g), 32'(cfg_err[g]), 1);
        rej_pend = 0;
      end
      for (int g = 0; g < 2; g++) begin
        if (i_strb[g]) begin
          if (stb[g] == 0) first[g] = cyc;
          last[g] = cyc;
          stb[g]++;
        end
        if (done[g]) dn[g]++;
        if (h_write[g]) begin
          if (hw[g] == 0) hwf[g] = cyc;
          hwl[g] = cyc;
          hw[g]++;
        end
      end
      if (rej && !rej_done && src_req[0]) begin
        cfg_we = 1'b1; cfg_idx = 4'd3; cfg_data = 8'hEE;
        rej_pend = 1; rej_done = 1;
      end
      extra_o = inj && cyc >= 9 && cyc < 30;
      tick();
      cyc++;
    end
    extra_o = 1'b0;
    cfg_we  = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s g%0d idle at end", nm, g), 32'(busy[g]), 0);
      chk($sformatf("%s g%0d strobes", nm, g), stb[g], TOT);
      chk($sformatf("%s g%0d done pulses", nm, g), dn[g], 1);
      chk($sformatf("%s g%0d h_write cycles", nm, g), hw[g], NT);
      chk($sformatf("%s g%0d h_write span", nm, g), hwl[g] - hwf[g] + 1, NT);
      chk($sformatf("%s g%0d out_cnt final", nm, g), 32'(out_cnt[g]), TOT);
      if (!rv)
        chk($sformatf("%s g%0d strobe span", nm, g), last[g] - first[g] + 1, (TOT - 1) * (2 * g + 1) + 1);
    end
    if (rej) chk($sformatf("%s busy write issued", nm), 32'(rej_done), 1);
  endtask

  initial begin
    int xf, cyc;
    for (int i = 0; i < 16; i++) bank_m[i] = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < NT; i++) cfg_write(i, i + 1, 1'b1);
    cfg_write(12, 8'h5A, 1'b0);
    run_frame("frameA", 1'b0, 1'b1, 1'b0);
    run_frame("frameB", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NT; i++) cfg_write(i, int'($urandom_range(0, 255)), 1'b1);
    run_frame("frameC", 1'b1, 1'b0, 1'b1);

    rnd_valid = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    xf = 0; cyc = 0;
    while (xf < 7 && cyc < 100) begin
      if (src_req[0] && src_valid) xf++;
      tick();
      cyc++;
    end
    chk("abort seven pixels", xf, 7);
    abort = 1'b1;
    chk("abort seventh strobe", 32'(i_strb[0]), 1);
    tick();
    abort = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("abort g%0d busy", g), 32'(busy[g]), 0);
      chk($sformatf("abort g%0d done", g), 32'(done[g]), 0);
      chk($sformatf("abort g%0d i_strb", g), 32'(i_strb[g]), 0);
    end
    tick();
    run_frame("after abort", 1'b0, 1'b0, 1'b0);

    go = 1'b1;
    tick();
    go = 1'b0;
    cyc = 0;
    while (!(h_write[0] && h_idx[0] == 4'd4) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("reached tap 4", 32'(h_idx[0]), 4);
    rst = 1'b1;
    #1;
    chk_all_zero("mid-load reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) bank_m[i] = '0;
    tick();
    for (int g = 0; g < 2; g++) chk($sformatf("post reset g%0d idle", g), 32'(busy[g]), 0);
    run_frame("post reset", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
